screen_region_arbiter: RTL

SCREEN_REGION_ARBITER -- requirements
Module: screen_region_arbiter

---
 rtl/screen_region_arbiter_pkg.sv | 30 +++
 rtl/screen_region_arbiter_region_hit_cell.sv | 26 ++
 rtl/screen_region_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/screen_region_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : screen_region_arbiter_pkg
//  Description : Region-entry record, commit FSM encoding and shared constants
//                for the screen region arbiter.
//  Revision    : 1.0
// ============================================================================
package screen_region_arbiter_pkg;

    // Region coordinates are stored at this width and zero-extended from COORD_W.
    localparam int c_max_coord_w = 16;
    localparam int c_def_blink_w = 5;

    typedef struct packed {
        logic [c_max_coord_w-1:0] x0;
        logic [c_max_coord_w-1:0] x1;
        logic [c_max_coord_w-1:0] y0;
        logic [c_max_coord_w-1:0] y1;
        logic                     en;
        logic                     blink;
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/screen_region_arbiter_region_hit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : region_hit_cell
//  Description : Tests one half-open rectangle against the current pixel.
//  Revision    : 1.0
// ============================================================================
module region_hit_cell
    import screen_region_arbiter_pkg::*;
(
    input  region_t                  i_region,
    input  logic [c_max_coord_w-1:0] i_h,
    input  logic [c_max_coord_w-1:0] i_v,
    input  logic                     i_blink_off,
    output logic                     o_hit
);

    logic w_in_x;
    logic w_in_y;

    // A degenerate rectangle (x1 <= x0 or y1 <= y0) can never satisfy both bounds.
    assign w_in_x = (i_h >= i_region.x0) && (i_h < i_region.x1);
    assign w_in_y = (i_v >= i_region.y0) && (i_v < i_region.y1);
    assign o_hit  = i_region.en && w_in_x && w_in_y && !(i_region.blink && i_blink_off);

endmodule
`default_nettype wire

// File: rtl/screen_region_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : screen_region_arbiter
//  Description : Priority hit-test of the pixel position against a table of
//                rectangles, with frame-synchronous double-buffered updates.
//  Revision    : 1.0
// ============================================================================
module screen_region_arbiter
    import screen_region_arbiter_pkg::*;
#(
    parameter int  NUM_REGIONS = 4,
    parameter int  COORD_W     = 10,
    parameter int  PIPE        = 1,
    parameter int  BLINK_W     = c_def_blink_w,
    localparam int IDX_W       = $clog2(NUM_REGIONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COORD_W-1:0]     h_readwire,
    input  logic [COORD_W-1:0]     v_readwire,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [COORD_W-1:0]     cfg_x0,
    input  logic [COORD_W-1:0]     cfg_x1,
    input  logic [COORD_W-1:0]     cfg_y0,
    input  logic [COORD_W-1:0]     cfg_y1,
    input  logic                   cfg_en,
    input  logic                   cfg_blink,
    input  logic                   cfg_commit,
    output logic [NUM_REGIONS-1:0] region_onehot,
    output logic [IDX_W-1:0]       region_idx,
    output logic                   region_hit,
    output logic                   frame_tick
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_apply;
    logic                     w_frame_start;
    logic                     w_cfg_wr;
    logic [COORD_W-1:0]       r_v_prev;
    logic [BLINK_W-1:0]       r_frame_cnt;
    region_t                  r_shadow [NUM_REGIONS];
    region_t                  r_active [NUM_REGIONS];
    region_t                  w_cfg_entry;
    logic [c_max_coord_w-1:0] w_h;
    logic [c_max_coord_w-1:0] w_v;
    logic [NUM_REGIONS-1:0]   w_hits;
    logic [NUM_REGIONS-1:0]   w_onehot;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_hit;
    logic [NUM_REGIONS-1:0]   r_onehot_q [PIPE];
    logic [IDX_W-1:0]         r_idx_q    [PIPE];
    logic [PIPE-1:0]          r_hit_q;

    assign w_frame_start = (v_readwire == '0) && (r_v_prev != '0);
    assign frame_tick    = w_frame_start;
    assign w_cfg_wr      = cfg_valid && cfg_ready && (int'(cfg_idx) < NUM_REGIONS);

    assign w_cfg_entry = '{x0:    c_max_coord_w'(cfg_x0),
                           x1:    c_max_coord_w'(cfg_x1),
                           y0:    c_max_coord_w'(cfg_y0),
                           y1:    c_max_coord_w'(cfg_y1),
                           en:    cfg_en,
                           blink: cfg_blink};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_v_prev    <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_v_prev <= v_readwire;
            if (w_frame_start) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                // A commit coinciding with a frame start waits for the next one.
                if (cfg_commit) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_frame_start) begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_apply     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_cfg_wr) begin
                r_shadow[cfg_idx] <= w_cfg_entry;
            end
            if (w_apply) begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign w_h = c_max_coord_w'(h_readwire);
    assign w_v = c_max_coord_w'(v_readwire);

    generate
        for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cell
            region_hit_cell u_cell (
                .i_region    (r_active[g]),
                .i_h         (w_h),
                .i_v         (w_v),
                .i_blink_off (r_frame_cnt[BLINK_W-1]),
                .o_hit       (w_hits[g])
            );
        end
    endgenerate

    // Scan from the top so the lowest hitting index is the last one written.
    always_comb begin
        w_onehot = '0;
        w_idx    = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hits[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_idx       = IDX_W'(i);
            end
        end
    end

    assign w_hit = |w_hits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPE; s++) begin
                r_onehot_q[s] <= '0;
                r_idx_q[s]    <= '0;
                r_hit_q[s]    <= 1'b0;
            end
        end else begin
            r_onehot_q[0] <= w_onehot;
            r_idx_q[0]    <= w_idx;
            r_hit_q[0]    <= w_hit;
            for (int s = 1; s < PIPE; s++) begin
                r_onehot_q[s] <= r_onehot_q[s-1];
                r_idx_q[s]    <= r_idx_q[s-1];
                r_hit_q[s]    <= r_hit_q[s-1];
            end
        end
    end

    assign region_onehot = r_onehot_q[PIPE-1];
    assign region_idx    = r_idx_q[PIPE-1];
    assign region_hit    = r_hit_q[PIPE-1];

endmodule
`default_nettype wire
